wb_stage_param: RTL and testbench

WB_STAGE_PARAM -- requirements
Module: wb_stage_param

---
 rtl/wb_stage_param.sv | 158 +++++++++++++++
 tb/tb_wb_stage_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_param.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_param
// Description : Writeback stage with a 2-entry skid FIFO, one-hot source
//               select, register forwarding and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_param #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 3,
    parameter int NUM_SRC = 3,
    parameter int WE_W    = 2,
    parameter int INSTR_W = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WE_W-1:0]           in_we,
    input  logic [REG_AW-1:0]         in_reg,
    input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
    input  logic [NUM_SRC-1:0]        in_src_sel,
    input  logic [INSTR_W-1:0]        in_instr,
    output logic                      rf_valid,
    input  logic                      rf_ready,
    output logic [WE_W-1:0]           rf_we,
    output logic [REG_AW-1:0]         rf_reg,
    output logic [DATA_W-1:0]         rf_data,
    output logic [INSTR_W-1:0]        wb_instr,
    input  logic [REG_AW-1:0]         fwd_reg,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data,
    output logic                      sel_error,
    output logic [15:0]               retire_count
);

    localparam logic [1:0] c_DEPTH = 2'd2;

    // Slot 0 is always the head; slot 1 is only meaningful when count == 2.
    logic [1:0]         r_count;
    logic [WE_W-1:0]    r_we    [2];
    logic [REG_AW-1:0]  r_reg   [2];
    logic [DATA_W-1:0]  r_data  [2];
    logic [INSTR_W-1:0] r_instr [2];
    logic               r_sel_error;
    logic [15:0]        r_retire_count;

    logic               w_push;
    logic               w_pop;
    logic               w_push_slot;
    logic               w_sel_onehot;
    logic [DATA_W-1:0]  w_masked [NUM_SRC];
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_hit0;
    logic               w_hit1;

    // ------------------------------------------------------------------
    // Source selection
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_masked[gi] = in_src_sel[gi] ? in_src_data[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    assign w_sel_onehot = (in_src_sel != '0) &&
                          ((in_src_sel & (in_src_sel - NUM_SRC'(1))) == '0);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sel_data = w_sel_data | w_masked[i];
        end
        if (!w_sel_onehot) begin
            w_sel_data = '0;
        end
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign in_ready = (r_count < c_DEPTH);
    assign rf_valid = (r_count != 2'd0);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = rf_valid & rf_ready;

    // A push lands in slot 1 only when the head stays put; otherwise slot 0.
    assign w_push_slot = (r_count == 2'd1) && !w_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count        <= 2'd0;
            r_sel_error    <= 1'b0;
            r_retire_count <= 16'd0;
            for (int i = 0; i < 2; i++) begin
                r_we[i]    <= '0;
                r_reg[i]   <= '0;
                r_data[i]  <= '0;
                r_instr[i] <= '0;
            end
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_push && !w_push_slot) begin
                r_we[0]    <= in_we;
                r_reg[0]   <= in_reg;
                r_data[0]  <= w_sel_data;
                r_instr[0] <= in_instr;
            end else if (w_pop) begin
                r_we[0]    <= r_we[1];
                r_reg[0]   <= r_reg[1];
                r_data[0]  <= r_data[1];
                r_instr[0] <= r_instr[1];
            end

            if (w_push && w_push_slot) begin
                r_we[1]    <= in_we;
                r_reg[1]   <= in_reg;
                r_data[1]  <= w_sel_data;
                r_instr[1] <= in_instr;
            end

            if (w_push && !w_sel_onehot) begin
                r_sel_error <= 1'b1;
            end

            if (w_pop) begin
                r_retire_count <= r_retire_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register-file port, zeroed while empty
    // ------------------------------------------------------------------
    assign rf_we        = rf_valid ? r_we[0]    : '0;
    assign rf_reg       = rf_valid ? r_reg[0]   : '0;
    assign rf_data      = rf_valid ? r_data[0]  : '0;
    assign wb_instr     = rf_valid ? r_instr[0] : '0;
    assign sel_error    = r_sel_error;
    assign retire_count = r_retire_count;

    // ------------------------------------------------------------------
    // Forwarding: the tail entry is younger, so it wins over the head
    // ------------------------------------------------------------------
    assign w_hit0 = (r_count != 2'd0) && (r_we[0] != '0) && (r_reg[0] == fwd_reg);
    assign w_hit1 = (r_count == 2'd2) && (r_we[1] != '0) && (r_reg[1] == fwd_reg);

    assign fwd_hit  = w_hit0 | w_hit1;
    assign fwd_data = w_hit1 ? r_data[1] :
                      w_hit0 ? r_data[0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_param
// Description : Directed self-checking bench for wb_stage_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_param;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_we;
    logic [2:0]  in_reg;
    logic [95:0] in_src_data;
    logic [2:0]  in_src_sel;
    logic [31:0] in_instr;
    logic        rf_valid;
    logic        rf_ready;
    logic [1:0]  rf_we;
    logic [2:0]  rf_reg;
    logic [31:0] rf_data;
    logic [31:0] wb_instr;
    logic [2:0]  fwd_reg;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        sel_error;
    logic [15:0] retire_count;

    int n_checks;
    int n_errors;
    logic [15:0] exp_retire;

    wb_stage_param dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_we        (in_we),
        .in_reg       (in_reg),
        .in_src_data  (in_src_data),
        .in_src_sel   (in_src_sel),
        .in_instr     (in_instr),
        .rf_valid     (rf_valid),
        .rf_ready     (rf_ready),
        .rf_we        (rf_we),
        .rf_reg       (rf_reg),
        .rf_data      (rf_data),
        .wb_instr     (wb_instr),
        .fwd_reg      (fwd_reg),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .sel_error    (sel_error),
        .retire_count (retire_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] we, input logic [2:0] rg,
                         input logic [2:0] sel, input logic [31:0] d, input logic [31:0] tag);
        in_valid    = v;
        in_we       = we;
        in_reg      = rg;
        in_src_sel  = sel;
        in_src_data = {d ^ 32'hAAAA_0002, d, d ^ 32'h5555_0000};
        if (sel == 3'b001) in_src_data[31:0]  = d;
        if (sel == 3'b100) in_src_data[95:64] = d;
        if (sel == 3'b001) in_src_data[63:32] = d ^ 32'h0F0F_0F0F;
        in_instr    = tag;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        rf_ready = 1'b0;
        fwd_reg  = 3'd0;
        tick();
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (rf_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rf_valid: got %b expected 0", rf_valid); end
        n_checks++; if ({rf_we, rf_reg, rf_data, wb_instr} !== '0) begin n_errors++; $display("FAIL reset_rf_fields: got %h expected 0", {rf_we, rf_reg, rf_data, wb_instr}); end
        n_checks++; if ({fwd_hit, fwd_data, sel_error, retire_count} !== '0) begin n_errors++; $display("FAIL reset_misc: got %h expected 0", {fwd_hit, fwd_data, sel_error, retire_count}); end
        reset = 1'b0;
        exp_retire = 16'd0;
        tick();
    endtask

    task automatic test_single_push();
        rf_ready = 1'b1;
        drive(1'b1, 2'b01, 3'd5, 3'b010, 32'hDEAD_BEEF, 32'h0000_0101);
        tick();
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        n_checks++; if (rf_valid !== 1'b1) begin n_errors++; $display("FAIL single_rf_valid: got %b expected 1", rf_valid); end
        n_checks++; if (rf_reg !== 3'd5) begin n_errors++; $display("FAIL single_rf_reg: got %0d expected 5", rf_reg); end
        n_checks++; if (rf_data !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL single_rf_data: got %h expected deadbeef", rf_data); end
        n_checks++; if (rf_we !== 2'b01 || wb_instr !== 32'h0000_0101) begin n_errors++; $display("FAIL single_we_tag: got %b/%h expected 01/00000101", rf_we, wb_instr); end
        n_checks++; if (retire_count !== exp_retire) begin n_errors++; $display("FAIL single_retire_before: got %0d expected %0d", retire_count, exp_retire); end
        tick();
        exp_retire = exp_retire + 16'd1;
        n_checks++; if (retire_count !== exp_retire) begin n_errors++; $display("FAIL single_retire_after: got %0d expected %0d", retire_count, exp_retire); end
        n_checks++; if (rf_valid !== 1'b0 || rf_data !== 32'h0) begin n_errors++; $display("FAIL single_empty: got %b/%h expected 0/0", rf_valid, rf_data); end
    endtask

    task automatic test_backpressure();
        rf_ready = 1'b0;
        drive(1'b1, 2'b01, 3'd1, 3'b001, 32'hAAAA_0001, 32'hA0);
        tick();
        drive(1'b1, 2'b10, 3'd2, 3'b100, 32'hBBBB_0002, 32'hB0);
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_in_ready: got %b expected 0", in_ready); end
        drive(1'b1, 2'b11, 3'd3, 3'b010, 32'hCCCC_0003, 32'hC0);
        tick();
        n_checks++; if (in_ready !== 1'b0 || rf_data !== 32'hAAAA_0001) begin n_errors++; $display("FAIL bp_third_ignored: got %b/%h expected 0/aaaa0001", in_ready, rf_data); end
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        rf_ready = 1'b1;
        n_checks++; if (rf_reg !== 3'd1 || wb_instr !== 32'hA0) begin n_errors++; $display("FAIL bp_head_a: got %0d/%h expected 1/a0", rf_reg, wb_instr); end
        tick();
        n_checks++; if (rf_data !== 32'hBBBB_0002 || rf_we !== 2'b10 || rf_valid !== 1'b1) begin n_errors++; $display("FAIL bp_head_b: got %h/%b/%b expected bbbb0002/10/1", rf_data, rf_we, rf_valid); end
        tick();
        exp_retire = exp_retire + 16'd2;
        n_checks++; if (rf_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_drained: got %b/%b expected 0/1", rf_valid, in_ready); end
        n_checks++; if (retire_count !== exp_retire) begin n_errors++; $display("FAIL bp_retire: got %0d expected %0d", retire_count, exp_retire); end
    endtask

    task automatic test_back_to_back();
        rf_ready = 1'b0;
        drive(1'b1, 2'b01, 3'd0, 3'b100, 32'h0000_1000, 32'h100);
        tick();
        rf_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 2'b01, 3'(i), 3'b100, 32'h0000_1000 + 32'(i), 32'h100 + 32'(i));
            n_checks++; if (rf_valid !== 1'b1 || in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_count1 %0d: got %b/%b expected 1/1", i, rf_valid, in_ready); end
            n_checks++; if (rf_data !== 32'h0000_1000 + 32'(i - 1)) begin n_errors++; $display("FAIL b2b_order %0d: got %h expected %h", i, rf_data, 32'h0000_1000 + 32'(i - 1)); end
            tick();
        end
        exp_retire = exp_retire + 16'd10;
        n_checks++; if (retire_count !== exp_retire) begin n_errors++; $display("FAIL b2b_retire: got %0d expected %0d", retire_count, exp_retire); end
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        n_checks++; if (rf_data !== 32'h0000_100A || wb_instr !== 32'h10A) begin n_errors++; $display("FAIL b2b_last: got %h/%h expected 0000100a/10a", rf_data, wb_instr); end
        tick();
        exp_retire = exp_retire + 16'd1;
        n_checks++; if (rf_valid !== 1'b0 || retire_count !== exp_retire) begin n_errors++; $display("FAIL b2b_drain: got %b/%0d expected 0/%0d", rf_valid, retire_count, exp_retire); end
    endtask

    task automatic test_forwarding();
        rf_ready = 1'b0;
        fwd_reg  = 3'd2;
        drive(1'b1, 2'b01, 3'd2, 3'b001, 32'h11, 32'h200);
        tick();
        n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h11) begin n_errors++; $display("FAIL fwd_head: got %b/%h expected 1/11", fwd_hit, fwd_data); end
        drive(1'b1, 2'b01, 3'd2, 3'b001, 32'h22, 32'h201);
        tick();
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin n_errors++; $display("FAIL fwd_youngest: got %b/%h expected 1/22", fwd_hit, fwd_data); end
        fwd_reg = 3'd3;
        #1;
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_errors++; $display("FAIL fwd_miss: got %b/%h expected 0/0", fwd_hit, fwd_data); end
        fwd_reg  = 3'd2;
        rf_ready = 1'b1;
        tick();
        tick();
        exp_retire = exp_retire + 16'd2;
        rf_ready = 1'b0;
        drive(1'b1, 2'b00, 3'd2, 3'b001, 32'h33, 32'h202);
        #1;
        n_checks++; if (fwd_hit !== 1'b0) begin n_errors++; $display("FAIL fwd_same_cycle: got %b expected 0", fwd_hit); end
        tick();
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_errors++; $display("FAIL fwd_we0: got %b/%h expected 0/0", fwd_hit, fwd_data); end
        n_checks++; if (rf_valid !== 1'b1 || rf_we !== 2'b00 || wb_instr !== 32'h202) begin n_errors++; $display("FAIL we0_retire_view: got %b/%b/%h expected 1/00/202", rf_valid, rf_we, wb_instr); end
        rf_ready = 1'b1;
        tick();
        exp_retire = exp_retire + 16'd1;
        n_checks++; if (retire_count !== exp_retire) begin n_errors++; $display("FAIL we0_retire: got %0d expected %0d", retire_count, exp_retire); end
    endtask

    task automatic test_invalid_sel();
        rf_ready = 1'b0;
        n_checks++; if (sel_error !== 1'b0) begin n_errors++; $display("FAIL sel_err_initial: got %b expected 0", sel_error); end
        drive(1'b1, 2'b01, 3'd4, 3'b011, 32'h1234_5678, 32'h300);
        tick();
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        n_checks++; if (rf_data !== 32'h0 || sel_error !== 1'b1 || rf_valid !== 1'b1) begin n_errors++; $display("FAIL sel_bad: got %h/%b/%b expected 0/1/1", rf_data, sel_error, rf_valid); end
        rf_ready = 1'b1;
        tick();
        drive(1'b1, 2'b01, 3'd6, 3'b001, 32'h0000_6666, 32'h301);
        tick();
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        n_checks++; if (rf_data !== 32'h0000_6666 || sel_error !== 1'b1) begin n_errors++; $display("FAIL sel_held: got %h/%b expected 00006666/1", rf_data, sel_error); end
        tick();
        exp_retire = exp_retire + 16'd2;
        n_checks++; if (retire_count !== exp_retire) begin n_errors++; $display("FAIL sel_retire: got %0d expected %0d", retire_count, exp_retire); end
    endtask

    task automatic test_reset_mid_stall();
        rf_ready = 1'b0;
        fwd_reg  = 3'd7;
        drive(1'b1, 2'b11, 3'd7, 3'b010, 32'h7777_0001, 32'h400);
        tick();
        drive(1'b1, 2'b11, 3'd7, 3'b100, 32'h7777_0002, 32'h401);
        tick();
        n_checks++; if (in_ready !== 1'b0 || fwd_hit !== 1'b1) begin n_errors++; $display("FAIL stall_full: got %b/%b expected 0/1", in_ready, fwd_hit); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (rf_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL async_reset_hs: got %b/%b expected 0/1", rf_valid, in_ready); end
        n_checks++; if ({rf_we, rf_reg, rf_data, wb_instr, fwd_hit, fwd_data} !== '0) begin n_errors++; $display("FAIL async_reset_data: got %h expected 0", {rf_we, rf_reg, rf_data, wb_instr, fwd_hit, fwd_data}); end
        n_checks++; if (retire_count !== 16'd0 || sel_error !== 1'b0) begin n_errors++; $display("FAIL async_reset_cnt: got %0d/%b expected 0/0", retire_count, sel_error); end
        tick();
        n_checks++; if (rf_valid !== 1'b0) begin n_errors++; $display("FAIL reset_no_push: got %b expected 0", rf_valid); end
        reset = 1'b0;
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        tick();
        n_checks++; if (rf_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_empty: got %b/%b expected 0/1", rf_valid, in_ready); end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_retire = 16'd0;
        reset      = 1'b1;
        rf_ready   = 1'b0;
        fwd_reg    = 3'd0;
        drive(1'b0, 2'b00, 3'd0, 3'b001, 32'h0, 32'h0);
        test_reset();
        test_single_push();
        test_backpressure();
        test_back_to_back();
        test_forwarding();
        test_invalid_sel();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
